// File: rtl/shift_deserializer.sv
// Serial-in / parallel-out receiver: gathers WIDTH serial bits (MSB- or LSB-first)
// into a word and presents it through a one-entry valid/ready holding register.
module shift_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             shift,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] asm;
  logic             dir_q;

  logic             at_last;
  logic             dir;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] shifted;

  assign at_last = (bit_cnt == LAST_BIT);

  // Only the completing bit needs a free (or draining) holding register.
  assign ser_ready = !(out_valid && !out_ready && at_last);
  assign accept    = ser_valid && ser_ready && !frame_clr;
  assign complete  = accept && at_last;
  assign busy      = (bit_cnt != '0);

  // The first bit of a word picks the direction; later bits follow the latched one.
  always_comb begin
    dir     = (bit_cnt == '0) ? shift : dir_q;
    shifted = dir ? {asm[WIDTH-2:0], ser_in} : {ser_in, asm[WIDTH-1:1]};
  end

  // Assembly stage: bit counter, partial word and latched direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      asm     <= '0;
      dir_q   <= 1'b1;
    end else if (frame_clr) begin
      bit_cnt <= '0;
      asm     <= '0;
    end else if (accept) begin
      if (bit_cnt == '0) dir_q <= shift;
      if (at_last) begin
        bit_cnt <= '0;
        asm     <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        asm     <= shifted;
      end
    end
  end

  // Output stage: holding register; a completing word may refill it on the drain edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out       <= shifted;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in / parallel-out receiver. It is the far end of the shift-register serial link: it reassembles a bit stream into WIDTH-bit words, in either MSB-first or LSB-first order. The block has a serial valid/ready input, a one-word output holding register and a parallel valid/ready output. It sits between the serial link and the parallel datapath consumer.

Parameters:
WIDTH, 4, word width in bits (>= 2); bit counter width is $clog2(WIDTH).

Ports:
clk        input   1      rising-edge clock (single clock domain).
reset      input   1      asynchronous, active-low reset.
ser_in     input   1      serial data bit.
ser_valid  input   1      ser_in is valid this cycle.
ser_ready  output  1      block can accept a bit this cycle.
shift      input   1      1 = MSB-first (shift left, new bit enters at LSB); 0 = LSB-first (shift right, new bit enters at MSB).
frame_clr  input   1      synchronous abort; discards the partial word.
out        output  WIDTH  assembled word.
out_valid  output  1      out holds an unconsumed word.
out_ready  input   1      consumer accepts out this cycle.
busy       output  1      a partial word is in progress (bit_cnt != 0).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous) forces: asm=0, bit_cnt=0, dir_q=1, out=0, out_valid=0, busy=0.
  - ser_ready=1 while out_valid=0.
  - Any partial word in progress at reset is discarded.
- Bit acceptance: a bit is taken on a rising edge when ser_valid && ser_ready && !frame_clr.
- Direction:
  - When bit_cnt==0, dir_q <= shift on acceptance, and that same bit uses shift.
  - Later bits of the word use dir_q; changes on shift mid-word are ignored.
- Shift rules on acceptance:
  - dir=1: asm <= {asm[WIDTH-2:0], ser_in}.
  - dir=0: asm <= {ser_in, asm[WIDTH-1:1]}.
- Counter: bit_cnt increments 0..WIDTH-1.
- Word completion, on acceptance with bit_cnt==WIDTH-1:
  - out <= the shifted value, including the current bit.
  - out_valid <= 1; bit_cnt <= 0; asm <= 0.
- Latency: last bit accepted on edge N; out/out_valid visible after edge N, one cycle.
- Throughput: one word per WIDTH cycles when ser_valid and out_ready are held high; no bubbles.
- Output handshake:
  - Transfer when out_valid && out_ready.
  - out_valid clears after a transfer unless a new word completes on the same edge; then out_valid stays 1 and out takes the new word.
  - out is stable while out_valid && !out_ready.
- ser_ready = !(out_valid && !out_ready && bit_cnt==WIDTH-1).
  - Combinational from out_ready.
  - Only the completing bit stalls; the first WIDTH-1 bits of the next word are accepted under backpressure.
- frame_clr (synchronous):
  - bit_cnt <= 0, asm <= 0.
  - Wins over bit acceptance on the same edge; that bit is dropped.
  - out/out_valid unaffected.
- busy = (bit_cnt != 0), registered-state derived.
- No overflow is possible: a completing bit is never accepted while the holding register is occupied and not draining.

Test Plan (WIDTH=4):
1. Reset:
   - Hold reset=0 for 2 cycles with ser_valid=1, ser_in toggling -> out=0000, out_valid=0, busy=0.
   - Release reset -> ser_ready=1.
2. MSB-first:
   - shift=1, out_ready=1, bits 1,0,1,0 on 4 consecutive edges -> out=1010.
   - out_valid=1 for exactly one cycle, starting the cycle after the 4th bit.
   - busy=1 after bits 1-3.
3. LSB-first:
   - shift=0, bits 1,0,1,0 -> out=0101, out_valid=1 one cycle after the 4th bit.
4. Backpressure:
   - out_ready=0; send 1,1,0,0 (MSB-first) -> out=1100, out_valid=1.
   - Send 3 bits of 0,1,1 -> accepted, busy=1.
   - 4th bit 1 -> ser_ready=0, out stays 1100.
   - Raise out_ready -> 4th bit accepted on the same edge; next cycle out=0111, out_valid=1.
5. Mid-word direction change:
   - shift=1 for bit 1, then shift=0 for bits 2-4, bits 1,1,0,1 -> out=1101 (MSB-first retained).
6. Abort and reset:
   - 2 bits, then frame_clr=1 with ser_valid=1 -> busy=0, bit dropped.
   - Then 0,0,1,1 -> out=0011.
   - Later assert reset after 2 bits -> busy=0, out_valid=0 immediately, without waiting for a clock edge.
